game_ctrl: RTL and testbench
============================

# game_ctrl

Game-flow controller that produces the `state`, `player1_score` and `player2_score` signals consumed by the text/score overlay stage in the VGA pipeline. It sequences menu, serve, play and game-over phases and counts points from the ball logic's miss pulses. It also times the serve delay in video frames using the vblnk edge of the timing stream, and declares a winner at a configurable score.

## Interface
Parameters:
- `WIN_SCORE`, default 5: points needed to win. Legal range is 1..15.
- `SERVE_FRAMES`, default 60: frames spent in serve before play resumes. Legal range is 1..1023.
- `OVER_FRAMES`, default 300: frames spent in game_over before auto-return. Legal range is 1..1023. Used only with `GAME_CTRL_AUTO_RETURN_EN`.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`, input, 1: pixel clock.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_start`, input, 1: start button level, already synchronized and debounced.
- `vblnk`, input, 1: vertical blank from the timing stream; its rising edge is the frame tick.
- `miss_left`, input, 1: one-cycle pulse; the ball passed player 1's paddle, so player 2 scores.
- `miss_right`, input, 1: one-cycle pulse; the ball passed player 2's paddle, so player 1 scores.
- `state`, output, 2: phase, using the vga_pkg encoding: menu_start=2'b00, serve=2'b01, play=2'b10, game_over=2'b11.
- `player1_score`, output, 4: player 1 points.
- `player2_score`, output, 4: player 2 points.
- `ball_rst`, output, 1: one-cycle pulse requesting ball recentre.
- `serve_dir`, output, 1: direction of the next serve; 0 = toward player 1, 1 = toward player 2.

## Operation
- Start edge: `start_edge = btn_start & ~btn_q`. The `btn_q` register resets to 1, so a button held through reset produces no start.
- Frame tick: `tick = vblnk & ~vblnk_q`. The `vblnk_q` register resets to 0.
- `frame_cnt` is 10 bits. It clears on every state change and increments on `tick`.
- menu_start:
  - `start_edge` moves to serve.
  - On the same edge, both scores clear to 0, `serve_dir` sets to 0, and `ball_rst` pulses.
- serve:
  - Misses are ignored.
  - Moves to play on the tick where `frame_cnt == SERVE_FRAMES-1`.
- play:
  - `miss_right` alone: `player1_score` increments and `serve_dir` becomes 1, i.e. toward the player who conceded.
  - `miss_left` alone: `player2_score` increments and `serve_dir` becomes 0.
  - Both misses in the same cycle: no point is awarded and `serve_dir` is unchanged.
  - Any miss pulses `ball_rst`.
  - After any miss, if the incremented score equals `WIN_SCORE`, move to game_over; otherwise move to serve.
  - `start_edge` is ignored.
- game_over:
  - Scores are held so the overlay can show the winner; ties cannot occur.
  - `start_edge` returns to menu_start.
  - Misses are ignored.
  - Auto-return is described under Configuration.
- Scores saturate at 15; they cannot exceed `WIN_SCORE` in practice.
- State 2'b11 reachable only via game_over; no illegal encodings exist.

## Timing
- All outputs are registered and update on the clk edge following the qualifying input cycle. Latency is 1 cycle from `miss_*` to score, state and `ball_rst`.
- `start_edge` is detected one cycle after the `btn_start` rise. State changes one cycle later, so total latency is 2 cycles.
- The serve phase lasts exactly `SERVE_FRAMES` frame ticks, counting the first tick after entry.
- `ball_rst` is high for exactly 1 cycle per event.
- Reset values: state=menu_start, both scores 0, `ball_rst` 0, `serve_dir` 0, `frame_cnt` 0.
- Reset asserted mid-game takes effect at the next clk edge and overrides any coincident input.

## Configuration
- Macro: `GAME_CTRL_AUTO_RETURN_EN`.
- Defined: game_over also returns to menu_start on the tick where `frame_cnt == OVER_FRAMES-1`. Whichever of `start_edge` or this timeout occurs first wins; if both occur in the same cycle, the result is a single transition.
- Undefined: game_over exits only on `start_edge`, and `OVER_FRAMES` is unused.

## Test plan
- Reset with `btn_start` high, then keep it held for 100 cycles. Required: state stays 2'b00. Release, then press. Required: state=2'b01 two cycles after the rise, scores 0/0, one `ball_rst` pulse.
- Enter serve with `SERVE_FRAMES`=3 and pulse vblnk. Required: state=2'b10 on the cycle after the 3rd vblnk rise; misses during serve leave scores at 0/0.
- In play, pulse `miss_right`. Required: `player1_score`=1, `serve_dir`=1, `ball_rst` 1 cycle, state=2'b01. Then pulse `miss_left` in play. Required: `player2_score`=1, `serve_dir`=0.
- Assert `miss_left` and `miss_right` together in play. Required: scores unchanged, `ball_rst` pulses, state=2'b01.
- With `WIN_SCORE`=2, play until player 2 reaches 2. Required: state=2'b11 with scores held at 0/2. Press start. Required: state=2'b00 with scores still 0/2; the next start clears them to 0/0.
- With `GAME_CTRL_AUTO_RETURN_EN` defined and `OVER_FRAMES`=2, idle in game_over. Required: return to 2'b00 after the 2nd tick. With the macro undefined, run 10 ticks. Required: state remains 2'b11.
- Assert rst for 1 cycle during play with scores 3/1. Required: next cycle state=2'b00, scores 0/0, `serve_dir` 0.

Source files
------------

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Brief    : Pong game-flow FSM (menu/serve/play/game_over) with score keeping
//            and vblnk-timed serve delay. Optional macro GAME_CTRL_AUTO_RETURN_EN
//            adds a timed return from game_over to menu.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       vblnk,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [1:0] state,
  output logic [3:0] player1_score,
  output logic [3:0] player2_score,
  output logic       ball_rst,
  output logic       serve_dir
);

  localparam logic [1:0] ST_MENU  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [9:0] SERVE_LAST = 10'(SERVE_FRAMES - 1);

  logic       btn_q, vblnk_q;
  logic       start_q, start_d;
  logic [1:0] state_q, state_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic       dir_q, dir_d;
  logic       ball_rst_q, ball_rst_d;
  logic [9:0] frame_cnt_q, frame_cnt_d;
  logic       tick;
  logic       over_timeout;
  logic [3:0] p1_inc, p2_inc;

  assign tick    = vblnk & ~vblnk_q;
  assign start_d = btn_start & ~btn_q;
  assign p1_inc  = (p1_q == 4'd15) ? 4'd15 : p1_q + 4'd1;
  assign p2_inc  = (p2_q == 4'd15) ? 4'd15 : p2_q + 4'd1;

`ifdef GAME_CTRL_AUTO_RETURN_EN
  localparam logic [9:0] OVER_LAST = 10'(OVER_FRAMES - 1);
  assign over_timeout = tick && (frame_cnt_q == OVER_LAST);
`else
  logic [9:0] unused_over_frames;
  assign unused_over_frames = 10'(OVER_FRAMES);
  assign over_timeout       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    dir_d      = dir_q;
    ball_rst_d = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (start_q) begin
          state_d    = ST_SERVE;
          p1_d       = 4'd0;
          p2_d       = 4'd0;
          dir_d      = 1'b0;
          ball_rst_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick && (frame_cnt_q == SERVE_LAST)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_left || miss_right) begin
          ball_rst_d = 1'b1;
          state_d    = ST_SERVE;
          // serve goes toward the player who conceded; a double miss is a replay
          if (miss_right && !miss_left) begin
            p1_d  = p1_inc;
            dir_d = 1'b1;
            if (p1_inc == WIN_VAL) state_d = ST_OVER;
          end else if (miss_left && !miss_right) begin
            p2_d  = p2_inc;
            dir_d = 1'b0;
            if (p2_inc == WIN_VAL) state_d = ST_OVER;
          end
        end
      end
      ST_OVER: begin
        if (start_q || over_timeout) state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase

    if (state_d != state_q) frame_cnt_d = 10'd0;
    else if (tick)          frame_cnt_d = frame_cnt_q + 10'd1;
    else                    frame_cnt_d = frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q       <= 1'b1;
      vblnk_q     <= 1'b0;
      start_q     <= 1'b0;
      state_q     <= ST_MENU;
      p1_q        <= 4'd0;
      p2_q        <= 4'd0;
      dir_q       <= 1'b0;
      ball_rst_q  <= 1'b0;
      frame_cnt_q <= 10'd0;
    end else begin
      btn_q       <= btn_start;
      vblnk_q     <= vblnk;
      start_q     <= start_d;
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      dir_q       <= dir_d;
      ball_rst_q  <= ball_rst_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign state         = state_q;
  assign player1_score = p1_q;
  assign player2_score = p2_q;
  assign ball_rst      = ball_rst_q;
  assign serve_dir     = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Brief    : Scoreboard bench for game_ctrl (WIN_SCORE=4, SERVE_FRAMES=3,
//            OVER_FRAMES=2); expected output events are queued by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  localparam logic [1:0] MENU  = 2'b00;
  localparam logic [1:0] SERVE = 2'b01;
  localparam logic [1:0] PLAY  = 2'b10;
  localparam logic [1:0] OVER  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b1;
  logic       vblnk = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [1:0] state;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic       ball_rst;
  logic       serve_dir;

  game_ctrl #(
    .WIN_SCORE   (4),
    .SERVE_FRAMES(3),
    .OVER_FRAMES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .vblnk        (vblnk),
    .miss_left    (miss_left),
    .miss_right   (miss_right),
    .state        (state),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .ball_rst     (ball_rst),
    .serve_dir    (serve_dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       dir;
    logic       br;
  } exp_t;

  exp_t       sb[$];
  string      tags[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [10:0] prev_vec;

  // An output event is any change of state/scores/serve_dir, or ball_rst high.
  always @(negedge clk) begin
    logic [10:0] vec;
    exp_t        e;
    string       t;
    vec = {state, player1_score, player2_score, serve_dir};
    if (mon_en && ((vec != prev_vec) || ball_rst)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got st=%0d p1=%0d p2=%0d dir=%0b br=%0b required no output event",
                 cyc, state, player1_score, player2_score, serve_dir, ball_rst);
      end else begin
        e = sb.pop_front();
        t = tags.pop_front();
        if (e.cyc != cyc || e.st != state || e.p1 != player1_score ||
            e.p2 != player2_score || e.dir != serve_dir || e.br != ball_rst) begin
          errors++;
          $display("FAIL %s got cyc=%0d st=%0d p1=%0d p2=%0d dir=%0b br=%0b required cyc=%0d st=%0d p1=%0d p2=%0d dir=%0b br=%0b",
                   t, cyc, state, player1_score, player2_score, serve_dir, ball_rst,
                   e.cyc, e.st, e.p1, e.p2, e.dir, e.br);
        end
      end
    end
    prev_vec = vec;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input string tag, input int dc, input logic [1:0] st,
                           input logic [3:0] p1, input logic [3:0] p2,
                           input logic dir, input logic br);
    exp_t e;
    e.cyc = cyc + dc;
    e.st  = st;
    e.p1  = p1;
    e.p2  = p2;
    e.dir = dir;
    e.br  = br;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic press_start(input string tag, input bit ev, input logic [1:0] st,
                             input logic [3:0] p1, input logic [3:0] p2,
                             input logic dir, input logic br);
    if (ev) expect_ev(tag, 2, st, p1, p2, dir, br);
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(2);
  endtask

  task automatic miss(input string tag, input logic l, input logic r, input bit ev,
                      input logic [1:0] st, input logic [3:0] p1, input logic [3:0] p2,
                      input logic dir, input logic br);
    if (ev) expect_ev(tag, 1, st, p1, p2, dir, br);
    miss_left  = l;
    miss_right = r;
    step(1);
    miss_left  = 1'b0;
    miss_right = 1'b0;
    step(2);
  endtask

  // n vblnk pulses; the rise number ev_at (0 = none) is expected to cause an event
  task automatic ticks(input string tag, input int n, input int ev_at,
                       input logic [1:0] st, input logic [3:0] p1, input logic [3:0] p2,
                       input logic dir);
    for (int i = 1; i <= n; i++) begin
      vblnk = 1'b1;
      if (i == ev_at) expect_ev(tag, 1, st, p1, p2, dir, 1'b0);
      step(2);
      vblnk = 1'b0;
      step(3);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got no completion required finish before timeout", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    btn_start = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    checks++;
    if ({state, player1_score, player2_score, serve_dir, ball_rst} != 12'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d p1=%0d p2=%0d dir=%0b br=%0b required all 0",
               state, player1_score, player2_score, serve_dir, ball_rst);
    end
    mon_en = 1'b1;

    step(100);
    checks++;
    if (state != MENU) begin
      errors++;
      $display("FAIL held_btn_no_start got st=%0d required st=0", state);
    end
    btn_start = 1'b0;
    step(3);

    press_start("start_1", 1, SERVE, 4'd0, 4'd0, 1'b0, 1'b1);
    miss("serve_miss_r", 1'b0, 1'b1, 0, SERVE, 4'd0, 4'd0, 1'b0, 1'b0);
    miss("serve_miss_l", 1'b1, 1'b0, 0, SERVE, 4'd0, 4'd0, 1'b0, 1'b0);
    miss("serve_miss_b", 1'b1, 1'b1, 0, SERVE, 4'd0, 4'd0, 1'b0, 1'b0);
    ticks("serve_to_play_1", 3, 3, PLAY, 4'd0, 4'd0, 1'b0);
    press_start("start_in_play", 0, PLAY, 4'd0, 4'd0, 1'b0, 1'b0);

    miss("miss_right_1", 1'b0, 1'b1, 1, SERVE, 4'd1, 4'd0, 1'b1, 1'b1);
    ticks("serve_to_play_2", 3, 3, PLAY, 4'd1, 4'd0, 1'b1);
    miss("both_miss", 1'b1, 1'b1, 1, SERVE, 4'd1, 4'd0, 1'b1, 1'b1);
    ticks("serve_to_play_3", 3, 3, PLAY, 4'd1, 4'd0, 1'b1);
    miss("miss_left_1", 1'b1, 1'b0, 1, SERVE, 4'd1, 4'd1, 1'b0, 1'b1);
    ticks("serve_to_play_4", 3, 3, PLAY, 4'd1, 4'd1, 1'b0);
    miss("miss_right_2", 1'b0, 1'b1, 1, SERVE, 4'd2, 4'd1, 1'b1, 1'b1);
    ticks("serve_to_play_5", 3, 3, PLAY, 4'd2, 4'd1, 1'b1);
    miss("miss_right_3", 1'b0, 1'b1, 1, SERVE, 4'd3, 4'd1, 1'b1, 1'b1);
    ticks("serve_to_play_6", 3, 3, PLAY, 4'd3, 4'd1, 1'b1);

    // reset overrides a coincident winning miss
    expect_ev("reset_mid_play", 1, MENU, 4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    miss_right = 1'b1;
    step(1);
    rst = 1'b0;
    miss_right = 1'b0;
    step(3);

    press_start("start_2", 1, SERVE, 4'd0, 4'd0, 1'b0, 1'b1);
    ticks("serve_to_play_7", 3, 3, PLAY, 4'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      miss("p2_point", 1'b1, 1'b0, 1, SERVE, 4'd0, 4'(k), 1'b0, 1'b1);
      ticks("p2_serve_to_play", 3, 3, PLAY, 4'd0, 4'(k), 1'b0);
    end
    miss("p2_wins", 1'b1, 1'b0, 1, OVER, 4'd0, 4'd4, 1'b0, 1'b1);
    miss("over_miss_ignored", 1'b0, 1'b1, 0, OVER, 4'd0, 4'd4, 1'b0, 1'b0);
    press_start("over_start_to_menu", 1, MENU, 4'd0, 4'd4, 1'b0, 1'b0);
    press_start("menu_start_clears", 1, SERVE, 4'd0, 4'd0, 1'b0, 1'b1);
    ticks("serve_to_play_8", 3, 3, PLAY, 4'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      miss("p1_point", 1'b0, 1'b1, 1, SERVE, 4'(k), 4'd0, 1'b1, 1'b1);
      ticks("p1_serve_to_play", 3, 3, PLAY, 4'(k), 4'd0, 1'b1);
    end
    miss("p1_wins", 1'b0, 1'b1, 1, OVER, 4'd4, 4'd0, 1'b1, 1'b1);

`ifdef GAME_CTRL_AUTO_RETURN_EN
    ticks("auto_return", 2, 2, MENU, 4'd4, 4'd0, 1'b1);
    step(5);
    checks++;
    if (state != MENU) begin
      errors++;
      $display("FAIL auto_return_state got st=%0d required st=0", state);
    end
`else
    ticks("no_auto_return", 10, 0, OVER, 4'd4, 4'd0, 1'b1);
    step(5);
    checks++;
    if (state != OVER) begin
      errors++;
      $display("FAIL no_auto_return_state got st=%0d required st=3", state);
    end
`endif

    step(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending required 0 pending", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
